// File: rtl/serial_subtractor_if.sv
// Start/done handshake bundle between the ALU control sequencer and serial_subtractor.
// The op select only exists when SERIAL_SUB_ADD_EN is defined.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
`ifdef SERIAL_SUB_ADD_EN
  logic             op;

  modport master (output start, a, b, op, input busy, done, diff, bout, ovf);
  modport slave  (input start, a, b, op, output busy, done, diff, bout, ovf);
`else
  modport master (output start, a, b, input busy, done, diff, bout, ovf);
  modport slave  (input start, a, b, output busy, done, diff, bout, ovf);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first, one full-subtractor cell and a registered borrow.
// Define SERIAL_SUB_ADD_EN to add an op select (1 = subtract, 0 = add) latched with the operands.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic               clk,
  input logic               rst,
  serial_subtractor_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Returns {borrow_out, difference} of a ripple full-subtractor cell.
  function automatic logic [1:0] sub_cell(input logic ai, input logic bi, input logic br);
    sub_cell = {(~ai & bi) | (~ai & br) | (bi & br), ai ^ bi ^ br};
  endfunction

`ifdef SERIAL_SUB_ADD_EN
  // Returns {carry_out, sum} of a ripple full-adder cell.
  function automatic logic [1:0] add_cell(input logic ai, input logic bi, input logic ci);
    add_cell = {(ai & bi) | (ai & ci) | (bi & ci), ai ^ bi ^ ci};
  endfunction

  logic op_r;
`endif

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] diff_r;
  logic [CNT_W-1:0] cnt_r;
  logic             br_r;
  logic             bout_r;
  logic             ovf_r;
  logic             busy_r;
  logic             done_r;
  logic [1:0]       cell_s;
  logic             ovf_nxt_s;
  logic             busy_nxt_s;
  logic             done_nxt_s;
  logic             accept_s;
  logic             last_s;

  assign accept_s = (state_r != RUN) && bus.start;
  assign last_s   = (cnt_r == CNT_W'(WIDTH - 1));

  // Operand bit i sits in bit 0 of the shift registers; on the last bit that is the operand MSB.
  always_comb begin
    cell_s    = sub_cell(a_sh_r[0], b_sh_r[0], br_r);
    ovf_nxt_s = (a_sh_r[0] != b_sh_r[0]) && (cell_s[0] != a_sh_r[0]);
`ifdef SERIAL_SUB_ADD_EN
    if (op_r) begin
      cell_s    = sub_cell(a_sh_r[0], b_sh_r[0], br_r);
      ovf_nxt_s = (a_sh_r[0] != b_sh_r[0]) && (cell_s[0] != a_sh_r[0]);
    end else begin
      cell_s    = add_cell(a_sh_r[0], b_sh_r[0], br_r);
      ovf_nxt_s = (a_sh_r[0] == b_sh_r[0]) && (cell_s[0] != a_sh_r[0]);
    end
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a new start is taken in DONE as well as IDLE.
  always_comb begin
    state_nxt_s = IDLE;
    case (state_r)
      IDLE:    state_nxt_s = bus.start ? RUN : IDLE;
      RUN:     state_nxt_s = last_s ? DONE : RUN;
      DONE:    state_nxt_s = bus.start ? RUN : IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Handshake outputs are decoded from the next state so they leave the block registered.
  always_comb begin
    busy_nxt_s = (state_nxt_s == RUN);
    done_nxt_s = (state_nxt_s == DONE);
  end

  // Datapath: operand latch, serial shift, and result capture on the final bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_r <= '0;
      b_sh_r <= '0;
      diff_r <= '0;
      cnt_r  <= '0;
      br_r   <= 1'b0;
      bout_r <= 1'b0;
      ovf_r  <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
`ifdef SERIAL_SUB_ADD_EN
      op_r   <= 1'b1;
`endif
    end else begin
      busy_r <= busy_nxt_s;
      done_r <= done_nxt_s;
      if (accept_s) begin
        a_sh_r <= bus.a;
        b_sh_r <= bus.b;
        cnt_r  <= '0;
        br_r   <= 1'b0;
`ifdef SERIAL_SUB_ADD_EN
        op_r   <= bus.op;
`endif
      end else if (state_r == RUN) begin
        a_sh_r <= {1'b0, a_sh_r[WIDTH-1:1]};
        b_sh_r <= {1'b0, b_sh_r[WIDTH-1:1]};
        diff_r <= {cell_s[0], diff_r[WIDTH-1:1]};
        br_r   <= cell_s[1];
        if (last_s) begin
          cnt_r  <= '0;
          bout_r <= cell_s[1];
          ovf_r  <= ovf_nxt_s;
        end else begin
          cnt_r  <= cnt_r + CNT_W'(1);
        end
      end else begin
        cnt_r  <= cnt_r;
      end
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.diff = diff_r;
  assign bus.bout = bout_r;
  assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): arithmetic reference model plus directed vectors.
// Define SERIAL_SUB_ADD_EN to also exercise the add mode.
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: an operation accepted at edge n is busy for W cycles and reports at edge n+W.
  int         e_n;
  int         acc_e;
  logic [7:0] p_a, p_b;
  logic       p_op;
  logic       exp_busy, exp_done, exp_bout, exp_ovf;
  logic [7:0] exp_diff;

  initial begin
    e_n = 0; acc_e = -1; p_a = 8'h00; p_b = 8'h00; p_op = 1'b1;
    exp_busy = 1'b0; exp_done = 1'b0; exp_diff = 8'h00; exp_bout = 1'b0; exp_ovf = 1'b0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        acc_e = -1;
        exp_busy = 1'b0; exp_done = 1'b0; exp_diff = 8'h00; exp_bout = 1'b0; exp_ovf = 1'b0;
      end else begin
        e_n++;
        if (!exp_busy && bus.start) begin
          acc_e = e_n;
          p_a = bus.a;
          p_b = bus.b;
`ifdef SERIAL_SUB_ADD_EN
          p_op = bus.op;
`else
          p_op = 1'b1;
`endif
        end
        exp_busy = (acc_e >= 0) && (e_n - acc_e < W);
        exp_done = (acc_e >= 0) && (e_n - acc_e == W);
        if (exp_done) begin
          logic [8:0] full;
          int sa, sb, sr;
          sa = $signed(p_a);
          sb = $signed(p_b);
          if (p_op) begin
            full = {1'b0, p_a} - {1'b0, p_b};
            sr = sa - sb;
          end else begin
            full = {1'b0, p_a} + {1'b0, p_b};
            sr = sa + sb;
          end
          exp_diff = full[7:0];
          exp_bout = full[8];
          exp_ovf  = (sr > 127) || (sr < -128);
        end
      end
    end
  end

  // Compare DUT against the model every cycle; results are only meaningful while not busy.
  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", 32'(bus.busy), 32'(exp_busy));
      chk("done", 32'(bus.done), 32'(exp_done));
      if (!exp_busy) begin
        chk("diff", 32'(bus.diff), 32'(exp_diff));
        chk("bout", 32'(bus.bout), 32'(exp_bout));
        chk("ovf",  32'(bus.ovf),  32'(exp_ovf));
      end
    end
  end

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic op,
                        input logic [7:0] ed, input logic eb, input logic eo);
    int edges;
    int busy_cnt;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.start = 1'b1;
`ifdef SERIAL_SUB_ADD_EN
    bus.op = op;
`else
    if (op != 1'b1) $display("note: add requested without add build");
`endif
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = 8'h5A; bus.b = 8'hC3;
    edges = 0; busy_cnt = 0;
    while (!bus.done && edges < 20) begin
      if (bus.busy) busy_cnt++;
      @(negedge clk);
      edges++;
    end
    chk("latency", 32'(edges), 32'd8);
    chk("busy_cycles", 32'(busy_cnt), 32'd8);
    chk("lit_diff", 32'(bus.diff), 32'(ed));
    chk("lit_bout", 32'(bus.bout), 32'(eb));
    chk("lit_ovf",  32'(bus.ovf),  32'(eo));
    @(negedge clk);
    chk("done_pulse", 32'(bus.done), 32'd0);
  endtask

  initial begin
    int done_seen;
    logic [7:0] hs_exp [3];
    n_cmp = 0; n_bad = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.a = 8'h00; bus.b = 8'h00;
`ifdef SERIAL_SUB_ADD_EN
    bus.op = 1'b1;
`endif
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_diff", 32'(bus.diff), 32'd0);
    rst = 1'b0;

    run_op(8'h05, 8'h03, 1'b1, 8'h02, 1'b0, 1'b0);
    run_op(8'h03, 8'h05, 1'b1, 8'hFE, 1'b1, 1'b0);
    run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b0, 1'b1);
    run_op(8'h7F, 8'hFF, 1'b1, 8'h80, 1'b1, 1'b1);
    run_op(8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0);

    // Start held high, operands change every cycle; a=0xAA lands mid-run.
    hs_exp[0] = 8'h20; hs_exp[1] = 8'h29; hs_exp[2] = 8'h32;
    done_seen = 0;
    for (int j = 0; j <= 27; j++) begin
      if (bus.done) begin
        if (done_seen < 3) chk("hs_diff", 32'(bus.diff), 32'(hs_exp[done_seen]));
        chk("hs_spacing", 32'(j), 32'(9 * (done_seen + 1)));
        done_seen++;
      end
      if (j < 27) begin
        bus.start = 1'b1;
        bus.a = (j == 3) ? 8'hAA : 8'(8'h30 + j);
        bus.b = 8'h10;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    chk("hs_count", 32'(done_seen), 32'd3);

    // Asynchronous reset four cycles into RUN.
    bus.a = 8'h55; bus.b = 8'h11; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    chk("arst_diff", 32'(bus.diff), 32'd0);
    chk("arst_bout", 32'(bus.bout), 32'd0);
    chk("arst_ovf",  32'(bus.ovf),  32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_op(8'h10, 8'h01, 1'b1, 8'h0F, 1'b0, 1'b0);

`ifdef SERIAL_SUB_ADD_EN
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op(8'h05, 8'h03, 1'b1, 8'h02, 1'b0, 1'b0);
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor; computes a - b one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow.
- Area-cheap counterpart to the combinational full-adder ripple datapath in the Arithmetic library. Used where the ALU can trade latency for gates.
- Start/done handshake toward the ALU control sequencer.

Parameters:
- WIDTH, 8, operand and result width in bits (≥2).
- CNT_W, $clog2(WIDTH)+1, bit-position counter width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  request; sampled only when not busy.
- a  input  WIDTH  minuend; latched on accepted start.
- b  input  WIDTH  subtrahend; latched on accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when results become valid.
- diff  output  WIDTH  a - b modulo 2^WIDTH.
- bout  output  1  final borrow out (1 when a < b unsigned).
- ovf  output  1  signed overflow.

Behaviour:
- Reset (async, any state, including mid-operation): state=IDLE, busy=0, done=0, diff=0, bout=0, ovf=0, counter=0, internal borrow=0. The operation in flight is discarded.
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1 at edge k:
  - Latch a and b into shift registers.
  - Clear borrow and counter; go to RUN; busy=1 from edge k.
- RUN, each edge: take bit i = counter from the latched operands, then:
  - d = ai ^ bi ^ br
  - br_next = (~ai & bi) | (~ai & br) | (bi & br)
  - Shift d into diff from the MSB side (diff shifts right); increment counter.
- RUN, on the edge processing bit WIDTH-1 (edge k+WIDTH):
  - State goes to DONE; busy=0; done=1.
  - bout = final borrow.
  - ovf = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]), using the latched operands.
- DONE: done is high for exactly one cycle.
  - Next edge: go to IDLE, done=0. If start=1 on that edge, go straight to RUN instead.
- Latency: start-accept edge to done-visible is WIDTH edges. Back-to-back throughput is one result per WIDTH+1 cycles.
- start while busy=1 is ignored; operands are not re-latched.
- diff, bout and ovf hold their values from done until the next accepted start.
- From the accept edge onward, diff is undefined (shifting) while busy=1.
- a and b may change freely after the accept edge.
- Counter wraps only through the state change; it never exceeds WIDTH-1 in RUN.

Optional Feature:
- Macro: SERIAL_SUB_ADD_EN.
- Defined: adds input port op (1 bit), latched with the operands on accept.
  - op=1: subtract, as above.
  - op=0: add. The cell uses the carry form: s = ai^bi^c, c_next = (ai&bi)|(ai&c)|(bi&c).
  - In add mode, bout reports the final carry out, and ovf = (a[MSB]==b[MSB]) & (diff[MSB]!=a[MSB]).
- Undefined: no op port; always subtract; the add logic is not synthesized.

Test Plan (WIDTH=8):
- a=0x05, b=0x03, start one cycle -> done pulse 8 edges after accept; diff=0x02, bout=0, ovf=0; busy high for exactly 8 cycles.
- a=0x03, b=0x05 -> diff=0xFE, bout=1, ovf=0. a=0x80, b=0x01 -> diff=0x7F, bout=0, ovf=1.
- a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1. a=0x00, b=0x00 -> diff=0x00, bout=0, ovf=0.
- Handshake: start held high continuously with new a/b each cycle.
  - Operands are latched only at the accept edges; results are one per 9 cycles.
  - Mid-RUN start with a=0xAA does not disturb the current result.
- Reset: assert rst asynchronously (between clock edges) 4 cycles into RUN.
  - All outputs 0 immediately, state IDLE.
  - After release, a=0x10, b=0x01 -> diff=0x0F, with no residue from the aborted op.
- With SERIAL_SUB_ADD_EN, op=0:
  - a=0xFF, b=0x01 -> diff=0x00, bout=1, ovf=0.
  - a=0x7F, b=0x01 -> diff=0x80, bout=0, ovf=1.
